// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared pipeline constants: next-PC opcodes, reset defaults and target helpers.
// Imported by the fetch stage and by the D-stage decoder that drives npc_op.
package fetch_pc_ctrl_pkg;

   typedef enum logic [2:0] {
      NpcSeq = 3'd0,
      NpcBeq = 3'd1,
      NpcBne = 3'd2,
      NpcJ   = 3'd3,
      NpcJal = 3'd4,
      NpcJr  = 3'd5
   } npc_op_e;

   localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_3000;
   localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] INSTR_BYTES       = 32'd4;
   localparam logic [31:0] LINK_OFFSET       = 32'd8;

   // Offset is relative to the delay slot, hence the +4 before the scaled immediate.
   function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                 input logic [15:0] imm);
      return pc + INSTR_BYTES + {{14{imm[15]}}, imm, 2'b00};
   endfunction

   function automatic logic [31:0] jump_target(input logic [31:0] pc,
                                               input logic [25:0] index);
      return {pc[31:28], index, 2'b00};
   endfunction

endpackage

// File: rtl/fetch_npc.sv
// Combinational next-PC selection from the F-stage PC and the control word in D.
// Only the low 26 instruction bits matter here (jump index, branch immediate).
module fetch_npc
   import fetch_pc_ctrl_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] d_pc,
   input  logic [25:0] d_index,
   input  logic        d_valid,
   input  logic [2:0]  npc_op,
   input  logic        beq_judge,
   input  logic        bne_judge,
   input  logic [31:0] d_rs_val,
   output logic [31:0] npc
);

   logic [31:0] seq_pc;
   logic [31:0] br_pc;
   logic [31:0] jmp_pc;

   assign seq_pc = pc + INSTR_BYTES;
   assign br_pc  = branch_target(d_pc, d_index[15:0]);
   assign jmp_pc = jump_target(d_pc, d_index);

   // A bubble in D carries no control intent, so it never redirects.
   always_comb begin
      npc = seq_pc;
      if (d_valid) begin
         case (npc_op)
            NpcBeq:        npc = beq_judge ? br_pc : seq_pc;
            NpcBne:        npc = bne_judge ? br_pc : seq_pc;
            NpcJ, NpcJal:  npc = jmp_pc;
            NpcJr:         npc = d_rs_val;
            default:       npc = seq_pc;
         endcase
      end
   end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC register and F/D pipeline register with delay-slot redirects.
// The delay-slot instruction always advances; redirects only steer the next fetch.
module fetch_pc_ctrl
   import fetch_pc_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        d_clr,
   input  logic [31:0] i_inst_rdata,
   input  logic [2:0]  npc_op,
   input  logic        beq_judge,
   input  logic        bne_judge,
   input  logic [31:0] d_rs_val,
   output logic [31:0] i_inst_addr,
   output logic [31:0] d_pc,
   output logic [31:0] d_instr,
   output logic        d_valid,
   output logic [31:0] d_pc8
);

   logic [31:0] pc_q;
   logic [31:0] d_pc_q;
   logic [31:0] d_instr_q;
   logic        d_valid_q;
   logic [31:0] npc;

   fetch_npc u_npc (
      .pc        (pc_q),
      .d_pc      (d_pc_q),
      .d_index   (d_instr_q[25:0]),
      .d_valid   (d_valid_q),
      .npc_op    (npc_op),
      .beq_judge (beq_judge),
      .bne_judge (bne_judge),
      .d_rs_val  (d_rs_val),
      .npc       (npc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q      <= RESET_PC;
         d_pc_q    <= RESET_PC;
         d_instr_q <= NOP_INSTR;
         d_valid_q <= 1'b0;
      end else if (!stall) begin
         pc_q   <= npc;
         d_pc_q <= pc_q;
         if (d_clr) begin
            d_instr_q <= NOP_INSTR;
            d_valid_q <= 1'b0;
         end else begin
            d_instr_q <= i_inst_rdata;
            d_valid_q <= 1'b1;
         end
      end
   end

   assign i_inst_addr = pc_q;
   assign d_pc        = d_pc_q;
   assign d_instr     = d_instr_q;
   assign d_valid     = d_valid_q;
   assign d_pc8       = d_pc_q + LINK_OFFSET;

endmodule

// File: doc/fetch_pc_ctrl.md
FETCH_PC_CTRL -- requirements
Module: fetch_pc_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0000, meaning the instruction word loaded into D on reset or clear.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hazard-unit stall: hold PC and F/D register.
REQ-006 d_clr  input  1  clear F/D register to a bubble.
REQ-007 i_inst_rdata  input  32  instruction word returned for i_inst_addr, same cycle (combinational IM).
REQ-008 npc_op  input  3  D-stage control: 0 seq, 1 beq, 2 bne, 3 j, 4 jal, 5 jr; 6-7 treated as seq.
REQ-009 beq_judge  input  1  D-stage comparator result, operands equal.
REQ-010 bne_judge  input  1  D-stage comparator result, operands unequal.
REQ-011 d_rs_val  input  32  forwarded rs value in D, jr target.
REQ-012 i_inst_addr  output  32  current F-stage PC.
REQ-013 d_pc  output  32  PC of the instruction in D.
REQ-014 d_instr  output  32  instruction word in D.
REQ-015 d_valid  output  1  D holds a real fetched instruction, not a bubble.
REQ-016 d_pc8  output  32  d_pc+4+4, link value for jal.

Function
REQ-017 F-stage PC register SHALL drive i_inst_addr directly, with no combinational path from inputs.
REQ-018 Branch target SHALL be d_pc + 4 + (sign-extend(d_instr[15:0]) << 2), computed in 32-bit modulo-2^32 arithmetic.
REQ-019 Jump target SHALL be {d_pc[31:28], d_instr[25:0], 2'b00}; jr target SHALL be d_rs_val unmodified.
REQ-020 Next PC SHALL be selected as follows:
- branch target when npc_op=1 and beq_judge=1, or npc_op=2 and bne_judge=1;
- jump target when npc_op is 3 or 4;
- d_rs_val when npc_op=5;
- otherwise PC+4.
REQ-021 Delay-slot semantics: the instruction already in F (at D's PC+4) SHALL always advance to D; no redirect ever squashes it.
REQ-022 The taken/not-taken decision SHALL be qualified by d_valid; a bubble in D SHALL produce PC+4.
REQ-023 With stall=1 the PC, d_pc, d_instr and d_valid SHALL hold their values, and any redirect that cycle SHALL be ignored.
REQ-024 With stall=0 and d_clr=1 the PC SHALL advance normally, and D SHALL load d_instr=NOP_INSTR, d_pc=current PC, d_valid=0.
REQ-025 With stall=0 and d_clr=0, D SHALL load i_inst_rdata, i_inst_addr and d_valid=1.
REQ-026 Priority SHALL be reset > stall > d_clr > normal advance.
REQ-027 PC wrap-around at 32'hFFFF_FFFC + 4 SHALL yield 0 with no flag.
REQ-028 Redirect latency: the target SHALL appear on i_inst_addr exactly one cycle after the branch/jump is in D.

Reset
REQ-029 When reset=1 at a clock edge:
- PC SHALL load RESET_PC;
- d_instr SHALL load NOP_INSTR;
- d_pc SHALL load RESET_PC;
- d_valid SHALL load 0.
REQ-030 Reset asserted mid-redirect or mid-stall SHALL discard the pending redirect and the stall.
REQ-031 Outputs before the first reset edge are undefined; the bench SHALL not check them.

Structure
REQ-032 The npc_op encodings and RESET_PC/NOP_INSTR defaults SHALL live in the shared pipeline constants package used by the D-stage decoder.
REQ-033 One sub-module SHALL be used: fetch_npc, purely combinational next-PC selection; PC and F/D registers SHALL stay in fetch_pc_ctrl.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
- Reset then 3 free-running cycles -> i_inst_addr 3000, 3004, 3008, 300C; d_valid goes 0 then 1.
- beq in D at d_pc=3004, imm=16'hFFFF, beq_judge=1 -> delay slot 3008 enters D; next i_inst_addr=3004.
- bne at d_pc=3010, imm=16'h0004, bne_judge=0 -> sequential 3018.
- jal at d_pc=3020, instr[25:0]=26'h0000C40 -> next PC 00003100; d_pc8=3028.
- jr with d_rs_val=32'h0000_3400 plus stall=1 for 2 cycles -> PC and D held both cycles; 3400 fetched the cycle after stall drops.
- stall=1 and d_clr=1 together -> hold wins, d_valid unchanged; d_clr alone -> d_valid=0, d_instr=0.
- reset asserted in the same cycle as a taken beq -> PC=3000, no redirect.
